// File: rtl/ibis_period_meter_pkg.sv
// Shared types and defaults for the ibis period meter.
package ibis_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        COUNT,
        HOLD
    } ibis_meter_state_t;

    localparam int IBIS_METER_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/ibis_period_meter_if.sv
// Result channel of the period meter (valid/ready plus overflow flag).
// With IBIS_PERIOD_METER_CONTINUOUS_EN the sticky period_overrun flag is carried as well.
interface ibis_period_meter_if #(
    parameter int WIDTH = ibis_pkg::IBIS_METER_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] period_out;
    logic             period_overflow;
    logic             period_valid;
    logic             period_ready;
`ifdef IBIS_PERIOD_METER_CONTINUOUS_EN
    logic             period_overrun;

    modport master (
        output period_out,
        output period_overflow,
        output period_valid,
        output period_overrun,
        input  period_ready
    );

    modport slave (
        input  period_out,
        input  period_overflow,
        input  period_valid,
        input  period_overrun,
        output period_ready
    );
`else
    modport master (
        output period_out,
        output period_overflow,
        output period_valid,
        input  period_ready
    );

    modport slave (
        input  period_out,
        input  period_overflow,
        input  period_valid,
        output period_ready
    );
`endif
endinterface

// File: rtl/ibis_period_meter_edge_detect.sv
// Enable-gated sample register with a 0->1 pulse; inputs on disabled cycles are not observed.
module ibis_edge_detect (
    input  logic aclk,
    input  logic areset,
    input  logic enable,
    input  logic d,
    output logic rise
);

    logic d_prev;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            d_prev <= 1'b0;
        end else if (enable) begin
            d_prev <= d;
        end
    end

    assign rise = d & ~d_prev;

endmodule

// File: rtl/ibis_period_meter.sv
// Measures enabled cycles between two rising tick_in edges; continuous mode with IBIS_PERIOD_METER_CONTINUOUS_EN.
// IDLE: waiting for arm | WAIT_FIRST: waiting for opening edge | COUNT: counting | HOLD: result held until accepted
module ibis_period_meter
    import ibis_pkg::*;
#(
    parameter int WIDTH = IBIS_METER_DEFAULT_WIDTH
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                enable,
    input  logic                arm,
    input  logic                abort,
    input  logic                tick_in,
    output logic                busy,
    ibis_period_meter_if.master result
);

    logic              tick_rise;
    ibis_meter_state_t state;
    logic [WIDTH-1:0]  counter;
    logic              ovf;
    logic [WIDTH:0]    count_inc;
    logic              carry;
    logic [WIDTH-1:0]  count_sat;
    logic [WIDTH-1:0]  result_out;
    logic              result_ovf;
    logic              result_valid;

    ibis_edge_detect u_edge (
        .aclk   (aclk),
        .areset (areset),
        .enable (enable),
        .d      (tick_in),
        .rise   (tick_rise)
    );

    assign count_inc = {1'b0, counter} + {{WIDTH{1'b0}}, 1'b1};
    assign carry     = count_inc[WIDTH];
    assign count_sat = carry ? {WIDTH{1'b1}} : count_inc[WIDTH-1:0];
    assign busy      = (state == WAIT_FIRST) || (state == COUNT);

    assign result.period_out      = result_out;
    assign result.period_overflow = result_ovf;
    assign result.period_valid    = result_valid;

`ifdef IBIS_PERIOD_METER_CONTINUOUS_EN
    logic overrun;
    assign result.period_overrun = overrun;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            counter      <= '0;
            ovf          <= 1'b0;
            result_out   <= '0;
            result_ovf   <= 1'b0;
            result_valid <= 1'b0;
`ifdef IBIS_PERIOD_METER_CONTINUOUS_EN
            overrun      <= 1'b0;
`endif
        end else begin
`ifdef IBIS_PERIOD_METER_CONTINUOUS_EN
            // Output register drains independently of the measuring FSM.
            if (result_valid && result.period_ready) begin
                result_valid <= 1'b0;
            end
            if (arm) begin
                overrun <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (enable && arm) begin
                        state <= WAIT_FIRST;
                    end
                end
                WAIT_FIRST: begin
                    if (enable) begin
                        if (abort) begin
                            state <= IDLE;
                        end else if (tick_rise) begin
                            state   <= COUNT;
                            counter <= '0;
                            ovf     <= 1'b0;
                        end
                    end
                end
                COUNT: begin
                    if (enable) begin
                        if (abort) begin
                            state <= IDLE;
                        end else if (tick_rise) begin
`ifdef IBIS_PERIOD_METER_CONTINUOUS_EN
                            counter <= '0;
                            ovf     <= 1'b0;
                            if (!result_valid || result.period_ready) begin
                                result_out   <= count_sat;
                                result_ovf   <= ovf | carry;
                                result_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`else
                            result_out   <= count_sat;
                            result_ovf   <= ovf | carry;
                            result_valid <= 1'b1;
                            state        <= HOLD;
`endif
                        end else begin
                            counter <= count_sat;
                            if (carry) begin
                                ovf <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
`ifdef IBIS_PERIOD_METER_CONTINUOUS_EN
                    state <= IDLE;
`else
                    // Handshake is deliberately not gated by enable.
                    if (result_valid && result.period_ready) begin
                        result_valid <= 1'b0;
                        state        <= arm ? WAIT_FIRST : IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibis_period_meter.sv
// Directed bench for ibis_period_meter: WIDTH=16 and WIDTH=4 instances share one stimulus.
module tb_ibis_period_meter;

    logic aclk;
    logic areset;
    logic enable;
    logic arm;
    logic abort;
    logic tick_in;
    logic ready;
    logic busy16;
    logic busy4;

    int n_checks;
    int n_fail;

    ibis_period_meter_if #(.WIDTH(16)) bus16 ();
    ibis_period_meter_if #(.WIDTH(4))  bus4 ();

    assign bus16.period_ready = ready;
    assign bus4.period_ready  = ready;

    ibis_period_meter #(.WIDTH(16)) dut16 (
        .aclk    (aclk),
        .areset  (areset),
        .enable  (enable),
        .arm     (arm),
        .abort   (abort),
        .tick_in (tick_in),
        .busy    (busy16),
        .result  (bus16.master)
    );

    ibis_period_meter #(.WIDTH(4)) dut4 (
        .aclk    (aclk),
        .areset  (areset),
        .enable  (enable),
        .arm     (arm),
        .abort   (abort),
        .tick_in (tick_in),
        .busy    (busy4),
        .result  (bus4.master)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // One enabled cycle with tick_in = t; in toggle mode it is preceded by a
    // disabled cycle carrying a tick glitch that must stay invisible.
    task automatic en_cycle(input logic t, input bit toggle);
        if (toggle) begin
            enable  = 1'b0;
            tick_in = 1'b1;
            step();
        end
        enable  = 1'b1;
        tick_in = t;
        step();
    endtask

    task automatic do_arm();
        enable  = 1'b1;
        tick_in = 1'b0;
        arm     = 1'b1;
        step();
        arm     = 1'b0;
    endtask

    // Opening edge followed by p-1 quiet enabled cycles; caller issues the closing edge.
    task automatic do_count(input int p, input bit toggle);
        en_cycle(1'b1, toggle);
        for (int i = 0; i < p - 1; i++) en_cycle(1'b0, toggle);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step();
        step();
        n_checks++;
        if (bus16.period_valid !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_busy: got valid=%b busy=%b, want 0 0", bus16.period_valid, busy16);
        end
        areset = 1'b0;
        step();
        n_checks++;
        if (bus16.period_out !== 16'd0 || bus16.period_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got out=%0d ovf=%b, want 0 0", bus16.period_out, bus16.period_overflow);
        end
    endtask

`ifndef IBIS_PERIOD_METER_CONTINUOUS_EN
    task automatic test_single();
        do_arm();
        n_checks++;
        if (busy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_armed: got %b, want 1", busy16);
        end
        do_count(100, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b0 || busy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pre_close: got valid=%b busy=%b, want 0 1", bus16.period_valid, busy16);
        end
        en_cycle(1'b1, 1'b0);
        tick_in = 1'b0;
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd100 || bus16.period_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got valid=%b out=%0d ovf=%b, want 1 100 0",
                     bus16.period_valid, bus16.period_out, bus16.period_overflow);
        end
        n_checks++;
        if (bus4.period_out !== 4'd15 || bus4.period_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL single_w4_sat: got out=%0d ovf=%b, want 15 1", bus4.period_out, bus4.period_overflow);
        end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd100 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: got valid=%b out=%0d busy=%b, want 1 100 0",
                     bus16.period_valid, bus16.period_out, busy16);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_checks++;
        if (bus16.period_valid !== 1'b0 || busy16 !== 1'b0 || bus16.period_out !== 16'd100) begin
            n_fail++;
            $display("FAIL single_accept: got valid=%b busy=%b out=%0d, want 0 0 100",
                     bus16.period_valid, busy16, bus16.period_out);
        end
    endtask

    task automatic test_enable_toggle();
        do_arm();
        do_count(25, 1'b1);
        en_cycle(1'b1, 1'b1);
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd25) begin
            n_fail++;
            $display("FAIL toggle_result: got valid=%b out=%0d, want 1 25", bus16.period_valid, bus16.period_out);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        int periods[3];
        logic [3:0] exp_out[3];
        logic exp_ovf[3];
        periods = '{15, 16, 20};
        exp_out = '{4'd15, 4'd15, 4'd15};
        exp_ovf = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            do_arm();
            do_count(periods[k], 1'b0);
            en_cycle(1'b1, 1'b0);
            n_checks++;
            if (bus4.period_valid !== 1'b1 || bus4.period_out !== exp_out[k] || bus4.period_overflow !== exp_ovf[k]) begin
                n_fail++;
                $display("FAIL overflow_w4_p%0d: got valid=%b out=%0d ovf=%b, want 1 %0d %b", periods[k],
                         bus4.period_valid, bus4.period_out, bus4.period_overflow, exp_out[k], exp_ovf[k]);
            end
            n_checks++;
            if (bus16.period_out !== 16'(periods[k]) || bus16.period_overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL overflow_w16_p%0d: got out=%0d ovf=%b, want %0d 0", periods[k],
                         bus16.period_out, bus16.period_overflow, periods[k]);
            end
            ready = 1'b1;
            step();
            ready = 1'b0;
        end
    endtask

    task automatic test_abort();
        do_arm();
        do_count(40, 1'b0);
        abort = 1'b1;
        en_cycle(1'b0, 1'b0);
        abort = 1'b0;
        n_checks++;
        if (busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_count_busy: got %b, want 0", busy16);
        end
        en_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) en_cycle(1'b0, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_later_edge: got valid=%b busy=%b, want 0 0", bus16.period_valid, busy16);
        end
        do_arm();
        do_count(10, 1'b0);
        abort = 1'b1;
        en_cycle(1'b1, 1'b0);
        abort = 1'b0;
        en_cycle(1'b0, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_with_edge: got valid=%b busy=%b, want 0 0", bus16.period_valid, busy16);
        end
    endtask

    task automatic test_async_reset();
        do_arm();
        do_count(20, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if (busy16 !== 1'b0 || bus16.period_valid !== 1'b0 || bus16.period_out !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_count: got busy=%b valid=%b out=%0d, want 0 0 0",
                     busy16, bus16.period_valid, bus16.period_out);
        end
        step();
        areset = 1'b0;
        do_arm();
        do_count(30, 1'b0);
        en_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd30) begin
            n_fail++;
            $display("FAIL areset_pre_hold: got valid=%b out=%0d, want 1 30", bus16.period_valid, bus16.period_out);
        end
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if (bus16.period_valid !== 1'b0 || bus16.period_out !== 16'd0 || bus4.period_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_hold: got valid=%b out=%0d ovf4=%b, want 0 0 0",
                     bus16.period_valid, bus16.period_out, bus4.period_overflow);
        end
        step();
        areset = 1'b0;
        do_arm();
        do_count(7, 1'b0);
        en_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd7 || bus4.period_out !== 4'd7) begin
            n_fail++;
            $display("FAIL areset_fresh: got valid=%b out=%0d out4=%0d, want 1 7 7",
                     bus16.period_valid, bus16.period_out, bus4.period_out);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_arm();
        do_count(9, 1'b0);
        en_cycle(1'b1, 1'b0);
        tick_in = 1'b0;
        ready   = 1'b1;
        arm     = 1'b1;
        step();
        ready   = 1'b0;
        arm     = 1'b0;
        n_checks++;
        if (bus16.period_valid !== 1'b0 || busy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_rearm: got valid=%b busy=%b, want 0 1", bus16.period_valid, busy16);
        end
        do_count(12, 1'b0);
        en_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd12) begin
            n_fail++;
            $display("FAIL b2b_result: got valid=%b out=%0d, want 1 12", bus16.period_valid, bus16.period_out);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask
`else
    task automatic test_continuous();
        do_arm();
        do_count(40, 1'b0);
        en_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd40 || bus16.period_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_first: got valid=%b out=%0d overrun=%b, want 1 40 0",
                     bus16.period_valid, bus16.period_out, bus16.period_overrun);
        end
        for (int i = 0; i < 39; i++) en_cycle(1'b0, 1'b0);
        en_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd40 || bus16.period_overrun !== 1'b1 || busy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_dropped: got valid=%b out=%0d overrun=%b busy=%b, want 1 40 1 1",
                     bus16.period_valid, bus16.period_out, bus16.period_overrun, busy16);
        end
        do_arm();
        n_checks++;
        if (bus16.period_overrun !== 1'b0 || busy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_arm_clear: got overrun=%b busy=%b, want 0 1", bus16.period_overrun, busy16);
        end
        ready = 1'b1;
        for (int i = 0; i < 38; i++) en_cycle(1'b0, 1'b0);
        en_cycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus16.period_valid !== 1'b1 || bus16.period_out !== 16'd40) begin
                n_fail++;
                $display("FAIL cont_stream_%0d: got valid=%b out=%0d, want 1 40", k, bus16.period_valid, bus16.period_out);
            end
            en_cycle(1'b0, 1'b0);
            n_checks++;
            if (bus16.period_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_drain_%0d: got valid=%b, want 0", k, bus16.period_valid);
            end
            for (int i = 0; i < 38; i++) en_cycle(1'b0, 1'b0);
            en_cycle(1'b1, 1'b0);
        end
        ready = 1'b0;
        abort = 1'b1;
        en_cycle(1'b0, 1'b0);
        abort = 1'b0;
        n_checks++;
        if (busy16 !== 1'b0 || bus16.period_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_abort: got busy=%b overrun=%b, want 0 0", busy16, bus16.period_overrun);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        areset   = 1'b1;
        enable   = 1'b0;
        arm      = 1'b0;
        abort    = 1'b0;
        tick_in  = 1'b0;
        ready    = 1'b0;
        test_reset();
`ifndef IBIS_PERIOD_METER_CONTINUOUS_EN
        test_single();
        test_enable_toggle();
        test_overflow();
        test_abort();
        test_async_reset();
        test_back_to_back();
`else
        test_continuous();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibis_period_meter.md
Name: ibis_period_meter

Overview:
- Inverse of the phase accumulator: measures the number of enabled clock cycles between two rising edges of an event input.
- Presents the count on a valid/ready output, so it can be written straight back as a phase reload value for a countdown.
- Used for tempo/pitch capture and for closed-loop checking of the accumulator's phase_is_zero stream.

Parameters:
- WIDTH, 16, width of the period counter and the result.

Ports:
- aclk  input  1  clock
- areset  input  1  reset; asynchronous, active-high
- enable  input  1  clock enable for edge detection and counting
- arm  input  1  request one measurement; sampled only in IDLE with enable high
- abort  input  1  cancel a measurement in progress; ignored while holding a result
- tick_in  input  1  synchronous event input; measured edge is 0->1
- period_out  output  WIDTH  measured period in enabled cycles
- period_overflow  output  1  result saturated at all-ones
- period_valid  output  1  result held, awaiting consumer
- period_ready  input  1  consumer accepts result
- busy  output  1  state is WAIT_FIRST or COUNT

Behaviour:
- Reset: state=IDLE, counter=0, tick_prev=0, period_out=0, period_overflow=0, period_valid=0, busy=0. Reset mid-measurement discards everything.
- Edge detect: edge = tick_in & ~tick_prev. tick_prev updates only on enabled cycles. Edges on disabled cycles are not seen.
- State machine, all transitions gated by enable except the HOLD handshake:
  - IDLE: arm -> WAIT_FIRST.
  - WAIT_FIRST: edge -> COUNT with counter<=0. abort -> IDLE. abort and edge in the same cycle: abort wins.
  - COUNT, no edge: counter<=counter+1, saturating at all-ones. Saturating sets an internal ovf flag.
  - COUNT, edge: period_out<=sat(counter+1), period_overflow<=ovf or carry, period_valid<=1, go to HOLD. abort in the same cycle wins (-> IDLE, no result).
  - HOLD: period_valid=1 with period_out stable. period_valid & period_ready -> IDLE, valid drops next cycle. This handshake works regardless of enable.
  - HOLD with arm high during the handshake cycle: goes directly to WAIT_FIRST (back-to-back arm).
- Timing: edges on enabled cycles n and n+P give period_out=P. Minimum P=1 (edges on consecutive enabled cycles need tick_in to drop between them, so in practice P>=2).
- Result latency: period_valid rises one clock after the closing edge cycle.
- Overflow: if P >= 2^WIDTH, period_out=all-ones and period_overflow=1.
- busy is combinational from state. period_out holds its last value outside HOLD.

Optional Feature:
- Macro: IBIS_PERIOD_METER_CONTINUOUS_EN.
- With the macro:
  - The closing edge in COUNT also opens the next measurement (counter<=0, stay in COUNT).
  - The result goes to the output register if it is empty.
  - If the output register is still valid, the new result is dropped and a sticky output period_overrun (1 bit, reset 0, cleared by arm in any state) is set.
  - Stays in COUNT until abort. The HOLD state is unused.
- Without the macro: one-shot behaviour exactly as above. The period_overrun port does not exist.

Decomposition:
- Package ibis_pkg holds:
  - typedef enum logic [1:0] ibis_meter_state_t {IDLE, WAIT_FIRST, COUNT, HOLD}
  - localparam IBIS_METER_DEFAULT_WIDTH = 16
- Sub-module ibis_edge_detect: enable-gated register plus rise pulse, reusable elsewhere.
- Counter and FSM stay inline.

Test Plan:
- WIDTH=16, enable=1, arm pulse, tick_in edges at cycles 10 and 110 -> period_valid at cycle 111, period_out=100, overflow=0. Holds while ready=0, clears one cycle after ready=1.
- enable toggling 1,0,1,0... with edges on enabled cycles 25 enabled-cycles apart -> period_out=25.
- WIDTH=4, edges 20 enabled cycles apart -> period_out=15, period_overflow=1.
- abort in COUNT at cycle 50, then a later edge -> no period_valid, state IDLE, busy=0. Abort coincident with the closing edge -> no result.
- areset asserted mid-COUNT and in HOLD -> all outputs 0 immediately (asynchronous). A fresh arm then measures correctly.
- CONTINUOUS_EN: edges every 40 cycles, ready held 0 -> first result 40 held, second dropped, period_overrun=1. arm clears it, and ready=1 then streams 40,40,...
